// File: rtl/cpu_run_ctrl_if.sv
// Handshake/result bundle between the run controller and its board-level driver.
// The controller connects through the slave modport; the driver or bench uses master.
interface cpu_run_ctrl_if;
    logic        start;
    logic        csr_we;
    logic [31:0] csr_wdata;
    logic        cpu_rst;
    logic        busy;
    logic        done;
    logic        pass;
    logic        timeout;
    logic [30:0] fail_code;
    logic [31:0] cycle_count;

    modport master (
        output start, csr_we, csr_wdata,
        input  cpu_rst, busy, done, pass, timeout, fail_code, cycle_count
    );

    modport slave (
        input  start, csr_we, csr_wdata,
        output cpu_rst, busy, done, pass, timeout, fail_code, cycle_count
    );
endinterface

// File: rtl/cpu_run_ctrl.sv
// Sequences one RISC-V test run: reset hold, RUN with cycle count, CSR end-of-test, watchdog.
// Macro CPU_RUN_CTRL_WATCHDOG_EN builds the timeout comparator and TIMEOUT state.
module cpu_run_ctrl #(
    parameter int unsigned RESET_HOLD_CYCLES = 30,
    parameter int unsigned TIMEOUT_CYCLES    = 2000
) (
    input  logic             clk,
    input  logic             rst_n,
    cpu_run_ctrl_if.slave    bus
);

    typedef enum logic [2:0] {
        ST_IDLE    = 3'd0,
        ST_RESET   = 3'd1,
        ST_RUN     = 3'd2,
        ST_PASS    = 3'd3,
        ST_FAIL    = 3'd4,
        ST_TIMEOUT = 3'd5
    } state_e;

    localparam logic [15:0] HOLD_LAST = 16'(RESET_HOLD_CYCLES - 32'd1);

    if ((RESET_HOLD_CYCLES < 32'd1) || (RESET_HOLD_CYCLES > 32'd65535) ||
        (TIMEOUT_CYCLES < 32'd1)) begin : g_param_check
        $error("cpu_run_ctrl: parameter out of legal range");
    end

    state_e      state_q, state_d;
    logic [15:0] hold_q, hold_d;
    logic [31:0] count_q, count_d;
    logic [30:0] code_q, code_d;
    logic        cpu_rst_q;
    logic        busy_q;
    logic        done_q;
    logic        pass_q;
    logic        end_hit_s;
    logic        timeout_hit_s;

    assign end_hit_s = bus.csr_we & bus.csr_wdata[0];

`ifdef CPU_RUN_CTRL_WATCHDOG_EN
    localparam logic [31:0] TIMEOUT_LAST = 32'(TIMEOUT_CYCLES - 32'd1);
    logic timeout_q;
    assign timeout_hit_s = (count_q == TIMEOUT_LAST);
`else
    assign timeout_hit_s = 1'b0;
`endif

    // Next-state and datapath update for the run sequencer
    always_comb begin
        state_d = state_q;
        hold_d  = hold_q;
        count_d = count_q;
        code_d  = code_q;
        case (state_q)
            ST_IDLE, ST_PASS, ST_FAIL, ST_TIMEOUT: begin
                if (bus.start) begin
                    state_d = ST_RESET;
                    hold_d  = 16'd0;
                    count_d = 32'd0;
                    code_d  = 31'd0;
                end else begin
                    state_d = state_q;
                end
            end
            ST_RESET: begin
                if (hold_q == HOLD_LAST) begin
                    state_d = ST_RUN;
                    count_d = 32'd0;
                end else begin
                    hold_d = hold_q + 16'd1;
                end
            end
            ST_RUN: begin
                // An ending CSR write takes priority over the watchdog on the same cycle
                if (end_hit_s) begin
                    code_d  = bus.csr_wdata[31:1];
                    state_d = (bus.csr_wdata[31:1] == 31'd0) ? ST_PASS : ST_FAIL;
                end else if (timeout_hit_s) begin
                    state_d = ST_TIMEOUT;
                end else if (count_q != 32'hFFFF_FFFF) begin
                    count_d = count_q + 32'd1;
                end else begin
                    count_d = count_q;
                end
            end
            default: begin
                state_d = ST_IDLE;
            end
        endcase
    end

    // State, datapath and output registers; outputs are decoded from the next state
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q   <= ST_IDLE;
            hold_q    <= 16'd0;
            count_q   <= 32'd0;
            code_q    <= 31'd0;
            cpu_rst_q <= 1'b1;
            busy_q    <= 1'b0;
            done_q    <= 1'b0;
            pass_q    <= 1'b0;
        end else begin
            state_q   <= state_d;
            hold_q    <= hold_d;
            count_q   <= count_d;
            code_q    <= code_d;
            cpu_rst_q <= (state_d != ST_RUN);
            busy_q    <= (state_d == ST_RESET) || (state_d == ST_RUN);
            done_q    <= (state_d == ST_PASS) || (state_d == ST_FAIL) ||
                         (state_d == ST_TIMEOUT);
            pass_q    <= (state_d == ST_PASS);
        end
    end

`ifdef CPU_RUN_CTRL_WATCHDOG_EN
    // Timeout flag register
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            timeout_q <= 1'b0;
        end else begin
            timeout_q <= (state_d == ST_TIMEOUT);
        end
    end
    assign bus.timeout = timeout_q;
`else
    assign bus.timeout = 1'b0;
`endif

    assign bus.cpu_rst     = cpu_rst_q;
    assign bus.busy        = busy_q;
    assign bus.done        = done_q;
    assign bus.pass        = pass_q;
    assign bus.fail_code   = code_q;
    assign bus.cycle_count = count_q;

endmodule

// File: tb/tb_cpu_run_ctrl.sv
// Directed bench for cpu_run_ctrl with an event-based reference model and per-cycle compare.
module tb_cpu_run_ctrl;
    localparam int unsigned H = 30;
    localparam int unsigned T = 2000;
`ifdef CPU_RUN_CTRL_WATCHDOG_EN
    localparam bit WD = 1'b1;
`else
    localparam bit WD = 1'b0;
`endif

    logic clk   = 1'b0;
    logic rst_n = 1'b0;
    int   total = 0;
    int   bad   = 0;
    int   n;
    int   n2;

    cpu_run_ctrl_if bus();

    cpu_run_ctrl #(.RESET_HOLD_CYCLES(H), .TIMEOUT_CYCLES(T)) dut (
        .clk   (clk),
        .rst_n (rst_n),
        .bus   (bus)
    );

    always #5 clk = ~clk;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
        end
    endtask

    // Model: age = edges since the accepted start; first H edges are the hold, then RUN
    bit          m_started  = 1'b0;
    bit          m_finished = 1'b0;
    longint      m_age      = 0;
    int          m_res      = 0;
    longint      m_count    = 0;
    logic [30:0] m_code     = 31'd0;

    function automatic longint run_cnt(input longint age);
        return age - longint'(H) - 1;
    endfunction

    always @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            m_started  <= 1'b0;
            m_finished <= 1'b0;
            m_age      <= 0;
            m_res      <= 0;
            m_count    <= 0;
            m_code     <= 31'd0;
        end else if ((!m_started || m_finished) && bus.start) begin
            m_started  <= 1'b1;
            m_finished <= 1'b0;
            m_age      <= 1;
            m_res      <= 0;
            m_count    <= 0;
            m_code     <= 31'd0;
        end else if (m_started && !m_finished) begin
            if (m_age > H && bus.csr_we && bus.csr_wdata[0]) begin
                m_finished <= 1'b1;
                m_res      <= (bus.csr_wdata[31:1] == 31'd0) ? 0 : 1;
                m_code     <= bus.csr_wdata[31:1];
                m_count    <= run_cnt(m_age);
            end else if (WD && m_age > H && run_cnt(m_age) == longint'(T) - 1) begin
                m_finished <= 1'b1;
                m_res      <= 2;
                m_count    <= longint'(T) - 1;
            end else begin
                m_age <= m_age + 1;
            end
        end
    end

    always @(negedge clk) begin
        logic        e_rst, e_busy, e_done, e_pass, e_to;
        logic [30:0] e_code;
        logic [31:0] e_cnt;
        e_rst  = 1'b1;
        e_busy = 1'b0;
        e_done = 1'b0;
        e_pass = 1'b0;
        e_to   = 1'b0;
        e_code = 31'd0;
        e_cnt  = 32'd0;
        if (m_started && !m_finished) begin
            e_busy = 1'b1;
            if (m_age > H) begin
                e_rst = 1'b0;
                e_cnt = 32'(run_cnt(m_age));
            end
        end else if (m_finished) begin
            e_done = 1'b1;
            e_pass = (m_res == 0);
            e_to   = (m_res == 2);
            e_code = m_code;
            e_cnt  = 32'(m_count);
        end
        check("cyc_cpu_rst", 32'(bus.cpu_rst), 32'(e_rst));
        check("cyc_busy", 32'(bus.busy), 32'(e_busy));
        check("cyc_done", 32'(bus.done), 32'(e_done));
        check("cyc_pass", 32'(bus.pass), 32'(e_pass));
        check("cyc_timeout", 32'(bus.timeout), 32'(e_to));
        check("cyc_fail_code", 32'(bus.fail_code), 32'(e_code));
        check("cyc_cycle_count", bus.cycle_count, e_cnt);
    end

    task automatic pulse_start();
        bus.start = 1'b1;
        @(negedge clk);
        bus.start = 1'b0;
    endtask

    task automatic wait_hold(output int cnt);
        cnt = 0;
        while (bus.cpu_rst === 1'b1 && cnt < 200) begin
            cnt++;
            @(negedge clk);
        end
    endtask

    task automatic end_write(input logic [31:0] data);
        bus.csr_we    = 1'b1;
        bus.csr_wdata = data;
        @(negedge clk);
        bus.csr_we    = 1'b0;
        bus.csr_wdata = 32'd0;
    endtask

    initial begin
        bus.start     = 1'b0;
        bus.csr_we    = 1'b0;
        bus.csr_wdata = 32'd0;
        repeat (3) @(negedge clk);
        check("rst_cpu_rst", 32'(bus.cpu_rst), 32'd1);
        check("rst_busy", 32'(bus.busy), 32'd0);
        check("rst_count", bus.cycle_count, 32'd0);
        rst_n = 1'b1;
        @(negedge clk);

        // Reset hold length
        pulse_start();
        check("hold_busy", 32'(bus.busy), 32'd1);
        wait_hold(n);
        check("hold_len", 32'(n), 32'd30);

        // 100 RUN cycles with an ignored write and an ignored start, then pass
        for (int i = 0; i < 100; i++) begin
            if (i == 60) check("ignored_count", bus.cycle_count, 32'd60);
            bus.csr_we    = (i == 20);
            bus.csr_wdata = (i == 20) ? 32'h0000_0002 : 32'h0000_0000;
            bus.start     = (i == 40);
            @(negedge clk);
        end
        bus.start = 1'b0;
        end_write(32'h0000_0001);
        check("pass_done", 32'(bus.done), 32'd1);
        check("pass_pass", 32'(bus.pass), 32'd1);
        check("pass_code", 32'(bus.fail_code), 32'd0);
        check("pass_count", bus.cycle_count, 32'd100);
        check("pass_cpu_rst", 32'(bus.cpu_rst), 32'd1);

        // Restart from PASS, then fail with code 3
        pulse_start();
        check("restart_pass", 32'(bus.pass), 32'd0);
        check("restart_count", bus.cycle_count, 32'd0);
        check("restart_busy", 32'(bus.busy), 32'd1);
        wait_hold(n);
        check("restart_hold", 32'(n), 32'd30);
        repeat (10) @(negedge clk);
        end_write(32'h0000_0007);
        check("fail_done", 32'(bus.done), 32'd1);
        check("fail_pass", 32'(bus.pass), 32'd0);
        check("fail_code", 32'(bus.fail_code), 32'd3);
        check("fail_count", bus.cycle_count, 32'd10);

        // Watchdog: no CSR write
        pulse_start();
        wait_hold(n);
        n2 = 0;
        while (bus.done !== 1'b1 && n2 < 3000) begin
            n2++;
            @(negedge clk);
        end
`ifdef CPU_RUN_CTRL_WATCHDOG_EN
        check("wd_timeout", 32'(bus.timeout), 32'd1);
        check("wd_count", bus.cycle_count, 32'd1999);
        check("wd_cpu_rst", 32'(bus.cpu_rst), 32'd1);
        pulse_start();
        wait_hold(n);
        repeat (5) @(negedge clk);
`else
        check("nowd_timeout", 32'(bus.timeout), 32'd0);
        check("nowd_busy", 32'(bus.busy), 32'd1);
        check("nowd_count", bus.cycle_count, 32'd3000);
`endif

        // Asynchronous reset in RUN
        check("midrst_running", 32'(bus.cpu_rst), 32'd0);
        #2;
        rst_n = 1'b0;
        #1;
        check("midrst_cpu_rst", 32'(bus.cpu_rst), 32'd1);
        check("midrst_busy", 32'(bus.busy), 32'd0);
        check("midrst_count", bus.cycle_count, 32'd0);
        check("midrst_done", 32'(bus.done), 32'd0);
        @(negedge clk);
        rst_n = 1'b1;
        @(negedge clk);

        // Ending write on the timeout cycle wins
        pulse_start();
        wait_hold(n);
        repeat (T - 1) @(negedge clk);
        end_write(32'h0000_0001);
        check("coll_pass", 32'(bus.pass), 32'd1);
        check("coll_timeout", 32'(bus.timeout), 32'd0);
        check("coll_count", bus.cycle_count, 32'd1999);
        repeat (3) @(negedge clk);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end
endmodule

// File: doc/cpu_run_ctrl.md
# cpu_run_ctrl

Sequences one execution run of the RISC-V `cpu` in hardware:
- holds the core in reset for a programmed number of cycles, then releases it;
- counts execution cycles;
- watches the test-completion CSR write for the end of the test;
- stops the run with a watchdog timeout if the test never finishes.

It sits between the board-level start button/debug logic and the `cpu` reset input, so ISA test pass/fail and cycle counts are available on FPGA without a simulator.

## Interface

Parameters:
- `RESET_HOLD_CYCLES`, default 30: number of cycles `cpu_rst` stays high after a start; legal range 1..2^16-1.
- `TIMEOUT_CYCLES`, default 2000: maximum RUN cycles before timeout; legal range 1..2^32-1.

Ports:
- `clk` input 1: single clock for all logic.
- `rst_n` input 1: asynchronous, active-low reset.
- `start` input 1: single-cycle pulse that requests a run.
- `csr_we` input 1: the CPU writes the test CSR this cycle.
- `csr_wdata` input 32: data of that CSR write.
- `cpu_rst` output 1: active-high reset to `cpu`; registered.
- `busy` output 1: high in RESET and RUN.
- `done` output 1: high in PASS, FAIL and TIMEOUT; sticky.
- `pass` output 1: high only in PASS.
- `timeout` output 1: high only in TIMEOUT.
- `fail_code` output 31: `csr_wdata[31:1]` captured at test end; 0 otherwise.
- `cycle_count` output 32: number of RUN cycles; frozen at test end.

## Operation

States: IDLE, RESET, RUN, PASS, FAIL, TIMEOUT.

Reset values (`rst_n` low, applied asynchronously):
- state IDLE, `cpu_rst`=1.
- `busy`=0, `done`=0, `pass`=0, `timeout`=0.
- `fail_code`=0, `cycle_count`=0, hold counter 0.

Transitions:
- IDLE, `start`=1 → RESET. Hold counter cleared; `cpu_rst` stays 1.
- RESET: hold counter increments each cycle. When it equals `RESET_HOLD_CYCLES`-1 → RUN, and `cycle_count` is cleared.
- RUN: `cpu_rst`=0 and `cycle_count` increments by 1 each cycle.
  - `csr_we`=1 with `csr_wdata[0]`=1 ends the test: `fail_code`←`csr_wdata[31:1]`.
  - If `csr_wdata[31:1]`=0 → PASS, otherwise → FAIL.
  - `cycle_count` is not incremented in the ending cycle.
- RUN: `csr_we`=1 with `csr_wdata[0]`=0 is ignored.
- RUN: when `cycle_count` equals `TIMEOUT_CYCLES`-1 and no ending CSR write occurs → TIMEOUT.
- RUN: an ending CSR write in the same cycle as the timeout condition wins, giving PASS or FAIL.
- PASS, FAIL and TIMEOUT are terminal: `cpu_rst`=1 (the core is frozen) and `done`=1. All result outputs hold until the next `start`.
- `start` in any terminal state → RESET. `fail_code`, `cycle_count`, `pass` and `timeout` clear on that transition.
- `start` while `busy`=1 is ignored.
- `cycle_count` saturates at 2^32-1 and never wraps. This is only reachable with the watchdog compiled out.
- `rst_n` asserted mid-run: state goes to IDLE immediately and `cpu_rst` goes to 1 asynchronously.

## Timing

- All outputs are registered and decoded from state or registers. There are no combinational input-to-output paths.
- `start` sampled high at edge N → `busy`=1 after edge N.
- `cpu_rst` falls after edge N+`RESET_HOLD_CYCLES`, i.e. it is high for exactly `RESET_HOLD_CYCLES` cycles counted from RESET entry.
- End-of-test latency: an ending CSR write sampled at edge M → `done`/`pass` high and `cpu_rst` high after edge M. This is 1 cycle, and the CPU executes no further cycles in RUN.
- Final `cycle_count` equals the number of RUN cycles preceding the ending write.
- `rst_n` deassertion is assumed synchronized externally. The first active edge after deassertion samples `start`.

## Configuration

Macro `CPU_RUN_CTRL_WATCHDOG_EN`.

Defined:
- Timeout comparator and TIMEOUT state are built.
- Behaviour is exactly as described above.

Undefined:
- No comparator is synthesized and the TIMEOUT state is unreachable.
- `timeout` is tied to 0.
- RUN persists until an ending CSR write or `rst_n`, and `cycle_count` saturates.
- `TIMEOUT_CYCLES` is accepted but unused.

## Test plan

- Reset-hold check, `RESET_HOLD_CYCLES`=30: pulse `start` → `cpu_rst` high for exactly 30 cycles, `busy`=1 throughout.
- Pass check:
  - Stimulus: 100 RUN cycles, then `csr_we`=1 with `csr_wdata`=32'h0000_0001.
  - Response: next cycle `done`=1, `pass`=1, `fail_code`=0, `cycle_count`=100, `cpu_rst`=1.
- Fail check: `csr_we`=1 with `csr_wdata`=32'h0000_0007 → FAIL, `pass`=0, `fail_code`=3.
- Watchdog check:
  - With `CPU_RUN_CTRL_WATCHDOG_EN`, `TIMEOUT_CYCLES`=2000 and no CSR write → `timeout`=1 and `cycle_count`=1999.
  - With the macro undefined, the same stimulus run for 3000 cycles → still RUN, `timeout`=0.
- Collision and ignore check:
  - An ending write with value 1 on the timeout cycle → PASS, not TIMEOUT.
  - `csr_wdata`=32'h0000_0002 (bit0=0) → ignored, run continues.
  - `start` during RUN → no effect.
- Mid-run reset and restart check:
  - Drop `rst_n` in RUN → IDLE, `cpu_rst`=1 before the next edge, all results 0.
  - `start` from PASS → RESET, with `pass`, `fail_code` and `cycle_count` cleared.
